second_largest_change_logger: RTL and testbench
===============================================

Name: second_largest_change_logger

Overview:
- Downstream stage of the running second-largest tracker; consumes its registered `dout` stream on every clock.
- Detects each change in the tracked value and timestamps it with a free-running cycle counter.
- Queues (value, timestamp) events in a small FIFO; drains them through a valid/ready port to the debug/readout logic.
- Overflow is reported with a sticky flag.

Parameters:
- DATA_WIDTH, 32, width of the tracked value (matches the upstream tracker).
- TS_WIDTH, 16, width of the timestamp counter.
- DEPTH, 4, event FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  reset; asynchronous, active-low.
- din  input  DATA_WIDTH  tracked second-largest value; sampled every cycle.
- clear  input  1  synchronous epoch restart, active-high.
- out_ready  input  1  consumer accepts the head event.
- out_valid  output  1  head event available.
- out_data  output  DATA_WIDTH  value of the head event.
- out_ts  output  TS_WIDTH  timestamp of the head event.
- count  output  $clog2(DEPTH)+1  occupied entries.
- overflow  output  1  sticky; an event was lost.

Behaviour:
- Reset (resetn low, asynchronous): prev=0, ts=0, FIFO empty, out_valid=0, out_data=0, out_ts=0, count=0, overflow=0.
  - prev=0 matches the upstream tracker's reset value, so a quiescent upstream generates no event.
- Timestamp: ts register increments by 1 on every edge with clear=0; wraps from 2^TS_WIDTH-1 to 0 silently.
- Change detect: an event fires at edge k when din != prev.
  - Event content: (din, ts value before edge k).
  - prev <= din on every non-clear edge.
- Push: the event is written at edge k.
  - If the FIFO was empty, out_valid=1 and out_data/out_ts show the event after edge k. One cycle of latency from din change to out_valid.
- Pop: occurs at an edge where out_valid && out_ready. out_ready while out_valid=0 has no effect.
- Output stability: out_data/out_ts hold stable while out_valid && !out_ready. out_data/out_ts are registered FIFO-head outputs.
- Ordering: strict FIFO order; no coalescing of back-to-back changes, so one event per changing cycle.
- Full, push without pop: the new event is dropped, FIFO is unchanged, overflow <= 1.
- Full, push with pop in the same edge: both happen; no drop; count stays DEPTH.
- Empty, push with pop: impossible; out_valid=0 blocks the pop.
- clear=1 at an edge:
  - FIFO flushed, ts <= 0, prev <= 0, overflow <= 0, out_valid <= 0.
  - din that cycle is ignored and no event is generated; a pending pop is discarded.
  - clear has priority over every other action.
- resetn asserted mid-transfer: immediate return to reset state; no partial handshake survives.
- count is exact every cycle: +1 on push, -1 on pop, unchanged on both or neither.

Optional Feature:
- Macro: LOGGER_DROP_OLDEST_EN.
- Defined: when full and pushing without a pop, the oldest entry is discarded and the new event is written.
  - overflow <= 1; count stays DEPTH.
  - The head advances, so out_data/out_ts change to the next-oldest event even while out_valid && !out_ready. This is the one permitted exception to output stability.
- Undefined: drop-newest behaviour as specified above.

Decomposition:
- Shared package second_largest_pkg:
  - typedef chg_event_t, a struct {data[DATA_WIDTH], ts[TS_WIDTH]};
  - localparams for default DATA_WIDTH and TS_WIDTH.
- Sub-module change_event_fifo: synchronous FIFO of chg_event_t.
  - Controls: push, pop, flush, and drop_oldest (tied from the macro).
  - Outputs: head, count, full, empty.
- Top level holds prev, the ts counter, change detection and the overflow flag.

Test Plan:
- Reset, din=0 held 5 cycles -> out_valid stays 0, count=0, overflow=0.
- din 0→5 at the edge where ts=3 → after that edge: out_valid=1, out_data=5, out_ts=3. out_ready=1 → after the pop edge: out_valid=0.
- out_ready=0, din=1,2,3,4,5 on consecutive cycles from ts=10:
  - Default: FIFO holds (1,10)…(4,13), (5,14) is dropped, overflow=1.
  - LOGGER_DROP_OLDEST_EN: FIFO holds (2,11)…(5,14), head out_data=2, overflow=1.
- FIFO full, out_ready=1 and din changes to 9 in the same cycle → count stays 4, overflow stays 0, tail is (9,ts).
- TS_WIDTH=4: din change at ts=15, then at the next cycle → timestamps 15 then 0 (wrap).
- clear=1 with FIFO holding 3 entries, overflow=1 and din changing → next cycle: count=0, out_valid=0, overflow=0, ts=0. A later din change from 0→7 logs (7, ts measured from the clear).

Source files
------------

// File: rtl/second_largest_pkg.sv
// Shared types for the second-largest change logger.
// The event record pairs a tracked value with the cycle it changed on.
package second_largest_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_TS_WIDTH   = 16;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic [DEFAULT_TS_WIDTH-1:0]   ts;
    } chg_event_t;

endpackage

// File: rtl/second_largest_change_logger_fifo.sv
// change_event_fifo: small synchronous FIFO of change events.
// The head entry is kept in its own register so readout sees a stable,
// registered value; drop_oldest selects what happens when a push meets a full
// FIFO with no pop (discard the new event, or evict the oldest one).
module change_event_fifo
    import second_largest_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type event_t = chg_event_t
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic                   drop_oldest,
    input  event_t                 wr_event,
    output event_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    event_t          mem [DEPTH];
    logic [PW-1:0]   rd_q;
    logic [PW-1:0]   wr_q;
    logic [CW-1:0]   count_q;
    logic            valid_q;
    event_t          head_q;

    logic            full_now;
    logic            do_pop;
    logic            overwrite;
    logic            do_write;
    logic            rd_adv;
    logic [PW-1:0]   rd_next;
    logic [PW-1:0]   wr_next;
    logic [CW-1:0]   count_next;
    event_t          head_next;

    // Next-state decode: what is written, what is released and which entry becomes the head.
    always_comb begin
        full_now   = (count_q == CW'(DEPTH));
        do_pop     = pop && valid_q;
        overwrite  = push && full_now && !do_pop;
        do_write   = push && (!full_now || do_pop || drop_oldest);
        rd_adv     = do_pop || (overwrite && drop_oldest);
        rd_next    = rd_adv ? rd_q + PW'(1) : rd_q;
        wr_next    = do_write ? wr_q + PW'(1) : wr_q;
        count_next = count_q + CW'(do_write) - CW'(rd_adv);
        if (do_write && (wr_q == rd_next)) begin
            head_next = wr_event;
        end else begin
            head_next = mem[rd_next];
        end
    end

    // Storage, pointers and the registered head; flush empties without touching storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            if (do_write) begin
                mem[wr_q] <= wr_event;
            end
            rd_q    <= rd_next;
            wr_q    <= wr_next;
            count_q <= count_next;
            valid_q <= (count_next != '0);
            head_q  <= head_next;
        end
    end

    assign head  = head_q;
    assign count = count_q;
    assign full  = full_now;
    assign empty = !valid_q;

endmodule

// File: rtl/second_largest_change_logger.sv
// second_largest_change_logger: watches the second-largest tracker output,
// timestamps every change with a free-running cycle counter and queues the
// events for readout over a valid/ready port. A lost event sets a sticky flag.
// Optional build macro LOGGER_DROP_OLDEST_EN: on overflow evict the oldest
// queued event instead of discarding the newest one.
module second_largest_change_logger
    import second_largest_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TS_WIDTH   = DEFAULT_TS_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   clear,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TS_WIDTH-1:0]    out_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TS_WIDTH-1:0]   ts;
    } evt_t;

`ifdef LOGGER_DROP_OLDEST_EN
    localparam logic DROP_OLDEST = 1'b1;
`else
    localparam logic DROP_OLDEST = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] prev_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic                  overflow_q;

    logic                  push;
    logic                  pop;
    evt_t                  new_event;
    evt_t                  fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Change detection and handshake decode; clear suppresses both push and pop.
    always_comb begin
        push           = (din != prev_q) && !clear;
        pop            = !fifo_empty && out_ready && !clear;
        new_event.data = din;
        new_event.ts   = ts_q;
    end

    // Previous value, timestamp counter and the sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q     <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            prev_q     <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q <= din;
            ts_q   <= ts_q + TS_WIDTH'(1);
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    change_event_fifo #(
        .DEPTH   (DEPTH),
        .event_t (evt_t)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .pop         (pop),
        .flush       (clear),
        .drop_oldest (DROP_OLDEST),
        .wr_event    (new_event),
        .head        (fifo_head),
        .count       (count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head.data;
    assign out_ts    = fifo_head.ts;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_second_largest_change_logger.sv
// Directed self-checking bench for second_largest_change_logger.
// Uses a 4-bit timestamp so wrap-around is reachable in a few cycles.
module tb_second_largest_change_logger;

    localparam int DW  = 32;
    localparam int TSW = 4;
    localparam int DEP = 4;

    logic                  clk;
    logic                  resetn;
    logic [DW-1:0]         din;
    logic                  clear;
    logic                  out_ready;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [TSW-1:0]        out_ts;
    logic [$clog2(DEP):0]  count;
    logic                  overflow;

    int assertCount = 0;
    int failCount   = 0;

    second_largest_change_logger #(
        .DATA_WIDTH (DW),
        .TS_WIDTH   (TSW),
        .DEPTH      (DEP)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din       (din),
        .clear     (clear),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value to its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then settle past it.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic clr, input logic rdy);
        din       = d;
        clear     = clr;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Check the head event and occupancy together.
    task automatic checkHead(input string tag, input logic [31:0] d, input logic [31:0] t, input logic [31:0] c);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"},  out_data,       d);
        checkOutput({tag, "_ts"},    32'(out_ts),    t);
        checkOutput({tag, "_count"}, 32'(count),     c);
    endtask

    logic [31:0] expData [4];
    logic [31:0] expTs   [4];

    initial begin
        resetn    = 1'b0;
        din       = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid",    32'(out_valid), 32'd0);
        checkOutput("rst_count",    32'(count),     32'd0);
        checkOutput("rst_overflow", 32'(overflow),  32'd0);
        checkOutput("rst_data",     out_data,       32'd0);
        checkOutput("rst_ts",       32'(out_ts),    32'd0);
        resetn = 1'b1;

        // Quiescent upstream: no events.
        repeat (5) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("idle_valid",    32'(out_valid), 32'd0);
        checkOutput("idle_count",    32'(count),     32'd0);
        checkOutput("idle_overflow", 32'(overflow),  32'd0);

        // Single change at ts=3, then pop it.
        applyStimulus(0, 1'b1, 1'b0);
        repeat (3) applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(5, 1'b0, 1'b0);
        checkHead("single", 5, 3, 1);
        applyStimulus(5, 1'b0, 1'b1);
        checkOutput("single_pop_valid", 32'(out_valid), 32'd0);
        checkOutput("single_pop_count", 32'(count),     32'd0);

        // Five back-to-back changes starting at ts=10 with the consumer stalled.
        applyStimulus(0, 1'b1, 1'b0);
        repeat (10) applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        checkHead("burst_first", 1, 10, 1);
        applyStimulus(2, 1'b0, 1'b0);
        checkHead("burst_hold", 1, 10, 2);
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b0);
        checkOutput("burst_full_overflow", 32'(overflow), 32'd0);
        applyStimulus(5, 1'b0, 1'b0);
        checkOutput("burst_overflow", 32'(overflow), 32'd1);
`ifdef LOGGER_DROP_OLDEST_EN
        expData = '{32'd2, 32'd3, 32'd4, 32'd5};
        expTs   = '{32'd11, 32'd12, 32'd13, 32'd14};
`else
        expData = '{32'd1, 32'd2, 32'd3, 32'd4};
        expTs   = '{32'd10, 32'd11, 32'd12, 32'd13};
`endif
        for (int i = 0; i < 4; i++) begin
            checkHead($sformatf("burst_drain%0d", i), expData[i], expTs[i], 32'(4 - i));
            applyStimulus(5, 1'b0, 1'b1);
        end
        checkOutput("burst_empty_valid", 32'(out_valid), 32'd0);
        checkOutput("burst_sticky",      32'(overflow),  32'd1);

        // Timestamp wrap: changes at ts=15 and the following cycle (ts=0).
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("clr_overflow", 32'(overflow), 32'd0);
        repeat (15) applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(6, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        checkHead("wrap_a", 6, 15, 2);
        applyStimulus(7, 1'b0, 1'b1);
        checkHead("wrap_b", 7, 0, 1);
        applyStimulus(7, 1'b0, 1'b1);
        checkOutput("wrap_empty", 32'(out_valid), 32'd0);

        // Full FIFO with simultaneous push and pop: nothing lost (ts now 3).
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b0);
        checkHead("full", 1, 3, 4);
        applyStimulus(9, 1'b0, 1'b1);
        checkHead("pushpop", 2, 4, 4);
        checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
        expData = '{32'd2, 32'd3, 32'd4, 32'd9};
        expTs   = '{32'd4, 32'd5, 32'd6, 32'd7};
        for (int i = 0; i < 4; i++) begin
            checkHead($sformatf("pushpop_drain%0d", i), expData[i], expTs[i], 32'(4 - i));
            applyStimulus(9, 1'b0, 1'b1);
        end
        checkOutput("pushpop_empty", 32'(out_valid), 32'd0);

        // Overflow, pop to three entries, then clear with a changing din (ts now 12).
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b0);
        applyStimulus(5, 1'b0, 1'b0);
        applyStimulus(5, 1'b0, 1'b1);
        checkOutput("preclr_count",    32'(count),    32'd3);
        checkOutput("preclr_overflow", 32'(overflow), 32'd1);
        applyStimulus(20, 1'b1, 1'b1);
        checkOutput("clr_count",     32'(count),     32'd0);
        checkOutput("clr_valid",     32'(out_valid), 32'd0);
        checkOutput("clr_overflow2", 32'(overflow),  32'd0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(7, 1'b0, 1'b0);
        checkHead("postclr", 7, 2, 1);

        // Asynchronous reset in the middle of a pending handshake.
        out_ready = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("async_valid",    32'(out_valid), 32'd0);
        checkOutput("async_count",    32'(count),     32'd0);
        checkOutput("async_data",     out_data,       32'd0);
        checkOutput("async_ts",       32'(out_ts),    32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("after_rst_valid",    32'(out_valid), 32'd0);
        checkOutput("after_rst_overflow", 32'(overflow),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
